keypad_entry: RTL and testbench
===============================

# keypad_entry

Consumes the decoded keypad event stream (`value`, `valid_in`, `valid_digit`) and assembles it into a complete calculation request. It qualifies each key press with a stability/re-arm debouncer and accumulates decimal digits into a BCD operand. It latches the operator, then hands operand A, operand B and the op code to the arithmetic unit over a valid/ready handshake. It sits directly downstream of the keypad front end and upstream of the ALU and display driver.

## Interface
- `DIGITS`, default 4: BCD digits per operand.
- `DEB`, default 4: consecutive identical samples needed to accept a press or re-arm.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `value` in 4: key code. 0–9 digits, A add, B sub, C mul, D div, E clear, F equals.
- `valid_in` in 1: level, a key is currently pressed.
- `valid_digit` in 1: level, the pressed key is 0–9.
- `calc_ready` in 1: ALU can accept a request.
- `entry_bcd` out 4*DIGITS: operand currently being typed, least significant digit in [3:0].
- `digit_count` out clog2(DIGITS+1): digits typed into `entry_bcd`.
- `operand_a` out 4*DIGITS: latched first operand.
- `operand_b` out 4*DIGITS: second operand, valid with `calc_valid`.
- `op_code` out 2: 0 add, 1 sub, 2 mul, 3 div.
- `calc_valid` out 1: request pending.
- `entering_b` out 1: high while in S_ENTER_B.

## Operation
- **Debouncer.** The debouncer is `armed` after reset.
  - A press is accepted on the edge where `valid_in` has been sampled high for DEB consecutive edges while armed. `value` and `valid_digit` are sampled on that edge.
  - Acceptance clears `armed`.
  - `armed` sets again after DEB consecutive low samples.
  - Holding a key produces exactly one event.
- **State machine.** States are S_ENTER_A (reset state), S_ENTER_B and S_ISSUE.
- **Digit key, S_ENTER_A or S_ENTER_B.**
  - If `digit_count == DIGITS`, the key is ignored.
  - If `digit_count == 0` and the digit is 0, the key is ignored (no leading zeros).
  - Otherwise `entry_bcd <= {entry_bcd[4*DIGITS-5:0], value}` and `digit_count` increments.
- **Operator key (A–D).**
  - In S_ENTER_A: `operand_a <= entry_bcd` (0 when no digits typed), `op_code <= value-10`, entry cleared, go to S_ENTER_B.
  - In S_ENTER_B: only `op_code` is replaced; the entry is kept.
- **Equals (F).**
  - In S_ENTER_A: ignored.
  - In S_ENTER_B: `operand_b <= entry_bcd`, entry cleared, go to S_ISSUE.
- **Clear (E)** in any state: entry, `operand_a`, `operand_b` and `op_code` are zeroed and the FSM goes to S_ENTER_A. This also aborts a pending request.
- **S_ISSUE.**
  - `calc_valid` is high, and `operand_a`, `operand_b` and `op_code` are stable.
  - The transfer occurs on an edge with `calc_valid && calc_ready`; the FSM then returns to S_ENTER_A.
  - All keys except clear are dropped in this state.
- **Reset values.** All outputs are 0, the state is S_ENTER_A, `armed` = 1 and the debounce counter is 0.

## Timing
- Key to register update: the accepted edge itself. `entry_bcd`/`digit_count` reflect the key immediately after the DEB-th consecutive high sample.
- `calc_valid` rises on the edge that accepts F.
  - If `calc_ready` is already high, the request completes one cycle later, so `calc_valid` is high for exactly 1 cycle.
  - Otherwise `calc_valid` stays high until the transfer edge.
- Minimum spacing between accepted events is 2*DEB cycles.
- A `valid_in` glitch shorter than DEB samples is rejected, and it restarts the high count.
- Reset asserted mid-entry or mid-handshake overrides everything on the next edge. No request survives reset.
- Clear accepted in the same cycle `calc_ready` is high in S_ISSUE: clear wins and no transfer is counted.

## Configuration
- `KEYPAD_ENTRY_BACKSPACE_EN` defined: key E with `digit_count > 0` acts as backspace.
  - `entry_bcd <= entry_bcd >> 4` and `digit_count` decrements.
  - E with `digit_count == 0` performs the full clear.
  - In S_ISSUE, E always performs the full clear.
- Not defined: E is always a full clear as described above.

## Test plan
- Reset, then press 1,2,3 (each held 10 cycles, released 10): `entry_bcd` = 16'h0123, `digit_count` = 3, `calc_valid` = 0.
- Press 0,0,7 from empty: `entry_bcd` = 16'h0007, `digit_count` = 1. Press 1,2,3,4,5: `entry_bcd` = 16'h1234 and the fifth digit is ignored.
- Sequence 4,2,B,9,F with `calc_ready` = 0 for 5 cycles then 1: `operand_a` = 16'h0042, `op_code` = 1, `operand_b` = 16'h0009. `calc_valid` holds until the ready cycle, then 0, with state S_ENTER_A.
- Operator change: 5,A,C,3,F gives `op_code` = 2, `operand_a` = 16'h0005, `operand_b` = 16'h0003. A,F from reset gives operand_a = 0 and operand_b = 0 issued.
- Debounce: `valid_in` pulses of DEB-1 samples produce no change. A key held 1000 cycles produces one digit. A release of DEB-1 samples followed by re-press produces no second event.
- E during S_ISSUE (`calc_ready` = 0) zeroes all outputs, deasserts `calc_valid` and returns to S_ENTER_A. With `KEYPAD_ENTRY_BACKSPACE_EN`, the sequence 1,2,E gives `entry_bcd` = 16'h0001, `digit_count` = 1.

Source files
------------

// File: rtl/keypad_entry_if.sv
// Bundles the keypad event stream, the ALU request handshake and the entry
// status seen by the display; keypad_entry owns the slave side.
interface keypad_entry_if #(
  parameter int DIGITS = 4
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [3:0]    value;
  logic          valid_in;
  logic          valid_digit;
  logic          calc_ready;
  logic [W-1:0]  entry_bcd;
  logic [CW-1:0] digit_count;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [1:0]    op_code;
  logic          calc_valid;
  logic          entering_b;

  modport master (
    output value, valid_in, valid_digit, calc_ready,
    input  entry_bcd, digit_count, operand_a, operand_b, op_code,
           calc_valid, entering_b
  );

  modport slave (
    input  value, valid_in, valid_digit, calc_ready,
    output entry_bcd, digit_count, operand_a, operand_b, op_code,
           calc_valid, entering_b
  );
endinterface

// File: rtl/keypad_entry.sv
// Debounces keypad events, builds BCD operands and issues ALU requests.
// Optional: define KEYPAD_ENTRY_BACKSPACE_EN to make key E a backspace while digits are typed.
module keypad_entry #(
  parameter int DIGITS = 4,
  parameter int DEB    = 4
) (
  input logic           clk,
  input logic           reset_n,
  keypad_entry_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int DW = $clog2(DEB + 1);

  typedef enum logic [1:0] {S_ENTER_A, S_ENTER_B, S_ISSUE} state_e;

  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [W-1:0]  entry_bcd_q, entry_bcd_d;
  logic [CW-1:0] digit_count_q, digit_count_d;
  logic [W-1:0]  operand_a_q, operand_a_d;
  logic [W-1:0]  operand_b_q, operand_b_d;
  logic [1:0]    op_code_q, op_code_d;

  logic key_event, is_digit, is_op, is_clear, is_eq, do_clear;

  // One counter serves both phases: high samples while armed, low samples while disarmed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    armed_d   = armed_q;
    deb_cnt_d = deb_cnt_q;
    key_event = 1'b0;
    if (armed_q) begin
      if (!bus.valid_in) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == DW'(DEB - 1)) begin
        key_event = 1'b1;
        armed_d   = 1'b0;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end else begin
      if (bus.valid_in) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == DW'(DEB - 1)) begin
        armed_d   = 1'b1;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    is_digit = key_event && bus.valid_digit;
    is_op    = key_event && !bus.valid_digit && (bus.value[3:2] == 2'b10 || bus.value == 4'hC || bus.value == 4'hD);
    is_clear = key_event && !bus.valid_digit && (bus.value == 4'hE);
    is_eq    = key_event && !bus.valid_digit && (bus.value == 4'hF);
  end

  always_comb begin
    state_d       = state_q;
    entry_bcd_d   = entry_bcd_q;
    digit_count_d = digit_count_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    op_code_d     = op_code_q;
    do_clear      = 1'b0;

    case (state_q)
      S_ENTER_A, S_ENTER_B: begin
        if (is_digit) begin
          if (digit_count_q != CW'(DIGITS) && !(digit_count_q == '0 && bus.value == 4'd0)) begin
            entry_bcd_d   = {entry_bcd_q[W-5:0], bus.value};
            digit_count_d = digit_count_q + 1'b1;
          end
        end else if (is_op) begin
          op_code_d = 2'(bus.value - 4'd10);
          if (state_q == S_ENTER_A) begin
            operand_a_d   = entry_bcd_q;
            entry_bcd_d   = '0;
            digit_count_d = '0;
            state_d       = S_ENTER_B;
          end
        end else if (is_eq) begin
          if (state_q == S_ENTER_B) begin
            operand_b_d   = entry_bcd_q;
            entry_bcd_d   = '0;
            digit_count_d = '0;
            state_d       = S_ISSUE;
          end
        end else if (is_clear) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
          if (digit_count_q != '0) begin
            entry_bcd_d   = entry_bcd_q >> 4;
            digit_count_d = digit_count_q - 1'b1;
          end else begin
            do_clear = 1'b1;
          end
`else
          do_clear = 1'b1;
`endif
        end
      end
      S_ISSUE: begin
        // Clear beats a simultaneous transfer: the request is aborted, not delivered.
        if (is_clear)            do_clear = 1'b1;
        else if (bus.calc_ready) state_d  = S_ENTER_A;
      end
      default: state_d = S_ENTER_A;
    endcase

    if (do_clear) begin
      entry_bcd_d   = '0;
      digit_count_d = '0;
      operand_a_d   = '0;
      operand_b_d   = '0;
      op_code_d     = '0;
      state_d       = S_ENTER_A;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments; reset is synchronous, sampled on the clock edge.
    if (!reset_n) begin
      state_q       <= S_ENTER_A;
      armed_q       <= 1'b1;
      deb_cnt_q     <= '0;
      entry_bcd_q   <= '0;
      digit_count_q <= '0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      op_code_q     <= '0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      deb_cnt_q     <= deb_cnt_d;
      entry_bcd_q   <= entry_bcd_d;
      digit_count_q <= digit_count_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      op_code_q     <= op_code_d;
    end
  end

  assign bus.entry_bcd   = entry_bcd_q;
  assign bus.digit_count = digit_count_q;
  assign bus.operand_a   = operand_a_q;
  assign bus.operand_b   = operand_b_q;
  assign bus.op_code     = op_code_q;
  assign bus.calc_valid  = (state_q == S_ISSUE);
  assign bus.entering_b  = (state_q == S_ENTER_B);
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry (DIGITS=4, DEB=4) with hand-computed expectations.
module tb_keypad_entry;
  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   vcnt;

  keypad_entry_if #(.DIGITS(4)) kif ();

  keypad_entry #(.DIGITS(4), .DEB(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (kif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    kif.valid_in = 1'b0;
    kif.calc_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] key, input int hold = 10, input int rel = 10);
    kif.value       = key;
    kif.valid_digit = (key < 4'd10);
    kif.valid_in    = 1'b1;
    repeat (hold) @(negedge clk);
    kif.valid_in    = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    kif.value = 4'd0;
    kif.valid_in = 1'b0;
    kif.valid_digit = 1'b0;
    kif.calc_ready = 1'b0;

    do_reset();
    check("rst_entry", 32'(kif.entry_bcd), 32'h0);
    check("rst_count", 32'(kif.digit_count), 32'd0);
    check("rst_valid", 32'(kif.calc_valid), 32'd0);
    check("rst_opa", 32'(kif.operand_a), 32'h0);
    check("rst_entb", 32'(kif.entering_b), 32'd0);

    // 1,2,3
    press(4'd1); press(4'd2); press(4'd3);
    check("e123_entry", 32'(kif.entry_bcd), 32'h0123);
    check("e123_count", 32'(kif.digit_count), 32'd3);
    check("e123_valid", 32'(kif.calc_valid), 32'd0);

    // leading zeros suppressed
    do_reset();
    press(4'd0); press(4'd0); press(4'd7);
    check("lz_entry", 32'(kif.entry_bcd), 32'h0007);
    check("lz_count", 32'(kif.digit_count), 32'd1);

    // fifth digit ignored
    do_reset();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check("full_entry", 32'(kif.entry_bcd), 32'h1234);
    check("full_count", 32'(kif.digit_count), 32'd4);

    // 4,2,B,9,F with delayed ready
    do_reset();
    press(4'd4); press(4'd2); press(4'hB);
    check("sub_entb", 32'(kif.entering_b), 32'd1);
    check("sub_opa", 32'(kif.operand_a), 32'h0042);
    check("sub_cleared", 32'(kif.entry_bcd), 32'h0);
    press(4'd9); press(4'hF);
    check("sub_valid", 32'(kif.calc_valid), 32'd1);
    check("sub_opb", 32'(kif.operand_b), 32'h0009);
    check("sub_op", 32'(kif.op_code), 32'd1);
    check("sub_entry0", 32'(kif.entry_bcd), 32'h0);
    repeat (5) @(negedge clk);
    check("sub_hold", 32'(kif.calc_valid), 32'd1);
    kif.calc_ready = 1'b1;
    @(negedge clk);
    kif.calc_ready = 1'b0;
    check("sub_done", 32'(kif.calc_valid), 32'd0);
    check("sub_state_a", 32'(kif.entering_b), 32'd0);
    check("sub_opb_kept", 32'(kif.operand_b), 32'h0009);
    press(4'd5);
    check("post_xfer_digit", 32'(kif.entry_bcd), 32'h0005);

    // operator change, then clear in S_ISSUE
    do_reset();
    press(4'd5); press(4'hA); press(4'hC); press(4'd3); press(4'hF);
    check("chg_op", 32'(kif.op_code), 32'd2);
    check("chg_opa", 32'(kif.operand_a), 32'h0005);
    check("chg_opb", 32'(kif.operand_b), 32'h0003);
    check("chg_valid", 32'(kif.calc_valid), 32'd1);
    press(4'hE);
    check("clr_valid", 32'(kif.calc_valid), 32'd0);
    check("clr_opa", 32'(kif.operand_a), 32'h0);
    check("clr_opb", 32'(kif.operand_b), 32'h0);
    check("clr_op", 32'(kif.op_code), 32'd0);
    check("clr_entb", 32'(kif.entering_b), 32'd0);

    // A,F from reset issues zeros; reset then kills the request
    do_reset();
    press(4'hA); press(4'hF);
    check("af_valid", 32'(kif.calc_valid), 32'd1);
    check("af_opa", 32'(kif.operand_a), 32'h0);
    check("af_opb", 32'(kif.operand_b), 32'h0);
    do_reset();
    check("rst_kills_req", 32'(kif.calc_valid), 32'd0);

    // calc_ready already high: calc_valid lasts exactly one cycle
    do_reset();
    press(4'd8); press(4'hD);
    kif.calc_ready = 1'b1;
    kif.value = 4'hF;
    kif.valid_digit = 1'b0;
    kif.valid_in = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) kif.valid_in = 1'b0;
      if (kif.calc_valid) vcnt++;
    end
    kif.calc_ready = 1'b0;
    check("ready_pulse", 32'(vcnt), 32'd1);
    check("ready_op", 32'(kif.op_code), 32'd3);

    // clear wins over simultaneous ready
    do_reset();
    press(4'd6); press(4'hB); press(4'd2); press(4'hF);
    kif.value = 4'hE;
    kif.valid_digit = 1'b0;
    kif.valid_in = 1'b1;
    repeat (3) @(negedge clk);
    kif.calc_ready = 1'b1;
    @(negedge clk);
    kif.calc_ready = 1'b0;
    check("race_opa", 32'(kif.operand_a), 32'h0);
    check("race_valid", 32'(kif.calc_valid), 32'd0);
    kif.valid_in = 1'b0;
    repeat (10) @(negedge clk);

    // acceptance latency: exactly on the DEB-th high sample
    do_reset();
    kif.value = 4'd9;
    kif.valid_digit = 1'b1;
    kif.valid_in = 1'b1;
    repeat (3) @(negedge clk);
    check("lat_before", 32'(kif.digit_count), 32'd0);
    @(negedge clk);
    check("lat_at", 32'(kif.digit_count), 32'd1);
    kif.valid_in = 1'b0;
    repeat (10) @(negedge clk);

    // debounce: short pulses and broken runs rejected
    do_reset();
    for (int i = 0; i < 3; i++) press(4'd5, 3, 5);
    press(4'd5, 3, 1);
    press(4'd5, 3, 10);
    check("glitch_count", 32'(kif.digit_count), 32'd0);
    press(4'd7, 1000, 10);
    check("hold_entry", 32'(kif.entry_bcd), 32'h0007);
    check("hold_count", 32'(kif.digit_count), 32'd1);
    press(4'd8, 10, 3);
    press(4'd8, 10, 10);
    check("rearm_entry", 32'(kif.entry_bcd), 32'h0078);
    check("rearm_count", 32'(kif.digit_count), 32'd2);

    // E while typing
    do_reset();
    press(4'd1); press(4'd2); press(4'hE);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
    check("bs_entry", 32'(kif.entry_bcd), 32'h0001);
    check("bs_count", 32'(kif.digit_count), 32'd1);
`else
    check("e_entry", 32'(kif.entry_bcd), 32'h0);
    check("e_count", 32'(kif.digit_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
